systolic_array_top: RTL and testbench

- Weight-stationary systolic matrix-multiply engine with three row buffers: input, weight and output.
- Weights are streamed into a weight buffer, then shifted into the PE grid.
- Activation rows are buffered, skewed and driven through the PE grid; column partial sums are deskewed and captured in an output buffer, which is drained one row per cycle.
- Sits under the accelerator controller, which sequences all enables.

---
 rtl/systolic_array_pkg.sv | 17 +
 rtl/systolic_array_if.sv | 31 +++
 rtl/systolic_array_fifo.sv | 48 ++++
 rtl/systolic_pe.sv | 41 ++++
 rtl/systolic_array_top.sv | 125 ++++++++++++
 tb/tb_systolic_array_top.sv | 179 +++++++++++++++++
 6 files changed

// File: rtl/systolic_array_pkg.sv
// Shared geometry and widths for the weight-stationary systolic matmul engine.
// ARRAYHEIGHT must equal ARRAYWIDTH: every buffer holds one row per PE row.
package systolic_array_pkg;
   localparam int DATASIZE            = 8;
   localparam int ARRAYWIDTH          = 4;
   localparam int ARRAYHEIGHT         = 4;
   localparam int OUTPUT_BUF_DATASIZE = 32;
   localparam int DSP_DELAY           = 1;

   localparam int ROW_W = DATASIZE * ARRAYWIDTH;
   localparam int RES_W = OUTPUT_BUF_DATASIZE * ARRAYWIDTH;
   // cycles from an input-buffer pop to the row reaching the output-buffer write port
   localparam int LAT   = (ARRAYHEIGHT + ARRAYWIDTH - 1) * DSP_DELAY;

   typedef logic [DATASIZE-1:0]            elem_t;
   typedef logic [OUTPUT_BUF_DATASIZE-1:0] psum_t;
endpackage

// File: rtl/systolic_array_if.sv
// Control enables and row data between the accelerator controller and the array.
interface systolic_array_if;
   import systolic_array_pkg::*;

   logic             input_buffer_load_en;
   logic             input_buffer_out_en;
   logic             weight_buffer_load_en;
   logic             weight_buffer_out_en;
   logic             write_weight_en;
   logic             output_buffer_load_en;
   logic             output_buffer_out_en;
   logic [ROW_W-1:0] in_act;
   logic [ROW_W-1:0] in_weight;
   logic [RES_W-1:0] out_res;

   modport master (
      output input_buffer_load_en, input_buffer_out_en,
      output weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
      output output_buffer_load_en, output_buffer_out_en,
      output in_act, in_weight,
      input  out_res
   );

   modport slave (
      input  input_buffer_load_en, input_buffer_out_en,
      input  weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
      input  output_buffer_load_en, output_buffer_out_en,
      input  in_act, in_weight,
      output out_res
   );
endinterface

// File: rtl/systolic_array_fifo.sv
// Row FIFO with combinational head read; empty reads return zero, full pushes are dropped.
module systolic_array_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         valid
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign valid   = (count != '0);
   assign dout    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/systolic_pe.sv
// One processing element: stationary weight, multiply-accumulate, and DSP_DELAY
// register stages on both the rightward activation and downward partial-sum paths.
module systolic_pe
   import systolic_array_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  w_en,
   input  elem_t w_in,
   output elem_t w_out,
   input  elem_t act_in,
   output elem_t act_out,
   input  psum_t psum_in,
   output psum_t psum_out
);
   elem_t w_reg;
   elem_t act_sr  [DSP_DELAY];
   psum_t psum_sr [DSP_DELAY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_reg <= '0;
         for (int i = 0; i < DSP_DELAY; i++) begin
            act_sr[i]  <= '0;
            psum_sr[i] <= '0;
         end
      end else begin
         if (w_en) w_reg <= w_in;
         act_sr[0]  <= act_in;
         psum_sr[0] <= psum_in + OUTPUT_BUF_DATASIZE'(act_in) * OUTPUT_BUF_DATASIZE'(w_reg);
         for (int i = 1; i < DSP_DELAY; i++) begin
            act_sr[i]  <= act_sr[i-1];
            psum_sr[i] <= psum_sr[i-1];
         end
      end
   end

   assign w_out    = w_reg;
   assign act_out  = act_sr[DSP_DELAY-1];
   assign psum_out = psum_sr[DSP_DELAY-1];
endmodule

// File: rtl/systolic_array_top.sv
// Weight-stationary systolic matmul: input/weight/output row FIFOs around a PE grid,
// with activation skew on the way in and partial-sum deskew on the way out.
module systolic_array_top
   import systolic_array_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   systolic_array_if.slave  bus
);
   logic [ROW_W-1:0] in_head;
   logic [ROW_W-1:0] w_head;
   logic [RES_W-1:0] o_head;
   logic             in_nonempty;
   logic             w_nonempty;
   logic             o_nonempty;
   logic             act_valid;
   logic [ROW_W-1:0] act_row;
   logic [ROW_W-1:0] w_row;
   logic [RES_W-1:0] res_row;
   logic [RES_W-1:0] out_res_q;
   logic [LAT-1:0]   v_sr;

   elem_t act_h      [ARRAYHEIGHT][ARRAYWIDTH+1];
   elem_t w_link     [ARRAYHEIGHT+1][ARRAYWIDTH];
   psum_t psum_link  [ARRAYHEIGHT+1][ARRAYWIDTH];
   psum_t res_lane   [ARRAYWIDTH];

   systolic_array_fifo #(.W(ROW_W), .DEPTH(ARRAYHEIGHT)) u_in_buf (
      .clk, .rst,
      .push(bus.input_buffer_load_en), .pop(bus.input_buffer_out_en),
      .din(bus.in_act), .dout(in_head), .valid(in_nonempty)
   );

   systolic_array_fifo #(.W(ROW_W), .DEPTH(ARRAYHEIGHT)) u_w_buf (
      .clk, .rst,
      .push(bus.weight_buffer_load_en), .pop(bus.weight_buffer_out_en),
      .din(bus.in_weight), .dout(w_head), .valid(w_nonempty)
   );

   systolic_array_fifo #(.W(RES_W), .DEPTH(ARRAYHEIGHT)) u_out_buf (
      .clk, .rst,
      .push(bus.output_buffer_load_en && v_sr[LAT-1]), .pop(bus.output_buffer_out_en),
      .din(res_row), .dout(o_head), .valid(o_nonempty)
   );

   assign act_valid = bus.input_buffer_out_en && in_nonempty;
   assign act_row   = act_valid ? in_head : '0;
   assign w_row     = w_nonempty ? w_head : '0;

   // valid only needs the total latency; data lanes carry their own skew
   always_ff @(posedge clk or posedge rst) begin
      if (rst) v_sr <= '0;
      else     v_sr <= {v_sr[LAT-2:0], act_valid};
   end

   for (genvar k = 0; k < ARRAYHEIGHT; k++) begin : g_skew
      if (k == 0) begin : g_d0
         assign act_h[k][0] = act_row[k*DATASIZE +: DATASIZE];
      end else begin : g_dn
         localparam int DL = k * DSP_DELAY;
         elem_t sr [DL];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DL; i++) sr[i] <= '0;
            end else begin
               sr[0] <= act_row[k*DATASIZE +: DATASIZE];
               for (int i = 1; i < DL; i++) sr[i] <= sr[i-1];
            end
         end
         assign act_h[k][0] = sr[DL-1];
      end
   end

   // new weight rows enter at the bottom and shift upward, so the first row pushed ends in row 0
   for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_edge
      assign w_link[ARRAYHEIGHT][j] = w_row[j*DATASIZE +: DATASIZE];
      assign psum_link[0][j]        = '0;
   end

   for (genvar k = 0; k < ARRAYHEIGHT; k++) begin : g_row
      for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_col
         systolic_pe u_pe (
            .clk, .rst,
            .w_en    (bus.write_weight_en),
            .w_in    (w_link[k+1][j]),
            .w_out   (w_link[k][j]),
            .act_in  (act_h[k][j]),
            .act_out (act_h[k][j+1]),
            .psum_in (psum_link[k][j]),
            .psum_out(psum_link[k+1][j])
         );
      end
   end

   for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_deskew
      if (j == ARRAYWIDTH - 1) begin : g_d0
         assign res_lane[j] = psum_link[ARRAYHEIGHT][j];
      end else begin : g_dn
         localparam int DL = (ARRAYWIDTH - 1 - j) * DSP_DELAY;
         psum_t sr [DL];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DL; i++) sr[i] <= '0;
            end else begin
               sr[0] <= psum_link[ARRAYHEIGHT][j];
               for (int i = 1; i < DL; i++) sr[i] <= sr[i-1];
            end
         end
         assign res_lane[j] = sr[DL-1];
      end
   end

   always_comb begin
      res_row = '0;
      for (int j = 0; j < ARRAYWIDTH; j++)
         res_row[j*OUTPUT_BUF_DATASIZE +: OUTPUT_BUF_DATASIZE] = res_lane[j];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           out_res_q <= '0;
      else if (bus.output_buffer_out_en) out_res_q <= o_nonempty ? o_head : '0;
   end

   assign bus.out_res = out_res_q;
endmodule

// File: tb/tb_systolic_array_top.sv
// Scoreboard bench: expected result rows are queued as activations are accepted and
// compared as the output buffer is drained.
module tb_systolic_array_top;
   import systolic_array_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_array_if bus();

   systolic_array_top dut (.clk(clk), .rst(rst), .bus(bus));

   logic [RES_W-1:0] sb [$];
   logic [ROW_W-1:0] w_model [ARRAYHEIGHT];
   int n_chk  = 0;
   int n_pass = 0;
   int in_cnt = 0;

   task automatic check_val(input string tag, input logic [RES_W-1:0] got, input logic [RES_W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus.input_buffer_load_en  = 1'b0;
      bus.input_buffer_out_en   = 1'b0;
      bus.weight_buffer_load_en = 1'b0;
      bus.weight_buffer_out_en  = 1'b0;
      bus.write_weight_en       = 1'b0;
      bus.output_buffer_load_en = 1'b0;
      bus.output_buffer_out_en  = 1'b0;
      bus.in_act                = '0;
      bus.in_weight             = '0;
   endtask

   function automatic logic [RES_W-1:0] model_row(input logic [ROW_W-1:0] a);
      logic [RES_W-1:0]               r;
      logic [OUTPUT_BUF_DATASIZE-1:0] acc;
      r = '0;
      for (int j = 0; j < ARRAYWIDTH; j++) begin
         acc = '0;
         for (int k = 0; k < ARRAYHEIGHT; k++)
            acc += OUTPUT_BUF_DATASIZE'(a[k*DATASIZE +: DATASIZE]) *
                   OUTPUT_BUF_DATASIZE'(w_model[k][j*DATASIZE +: DATASIZE]);
         r[j*OUTPUT_BUF_DATASIZE +: OUTPUT_BUF_DATASIZE] = acc;
      end
      return r;
   endfunction

   // weights pushed, then shifted into the grid while activations are pushed; then streamed
   task automatic feed(input logic [ROW_W-1:0] w [4], input logic [ROW_W-1:0] a [5], input int n_act);
      int n_loop;
      for (int i = 0; i < 4; i++) begin
         bus.weight_buffer_load_en = 1'b1;
         bus.in_weight             = w[i];
         tick();
      end
      bus.weight_buffer_load_en = 1'b0;
      for (int i = 0; i < 4; i++) w_model[i] = w[i];
      n_loop = (n_act > 4) ? n_act : 4;
      for (int i = 0; i < n_loop; i++) begin
         bus.weight_buffer_out_en = (i < 4);
         bus.write_weight_en      = (i < 4);
         bus.input_buffer_load_en = (i < n_act);
         if (i < n_act) begin
            bus.in_act = a[i];
            if (in_cnt < ARRAYHEIGHT) begin
               in_cnt++;
               sb.push_back(model_row(a[i]));
            end
         end
         tick();
      end
      idle_all();
      bus.output_buffer_load_en = 1'b1;
      bus.input_buffer_out_en   = 1'b1;
      repeat (in_cnt + 2) tick();
      bus.input_buffer_out_en = 1'b0;
      in_cnt = 0;
      repeat (LAT + 2) tick();
      bus.output_buffer_load_en = 1'b0;
   endtask

   task automatic drain(input int n, input string tag, input bit hold);
      logic [RES_W-1:0] exp;
      for (int i = 0; i < n; i++) begin
         bus.output_buffer_out_en = 1'b1;
         tick();
         bus.output_buffer_out_en = 1'b0;
         if (sb.size() > 0) exp = sb.pop_front();
         else               exp = '0;
         check_val($sformatf("%s_row%0d", tag, i), bus.out_res, exp);
         if (hold && i == 0) begin
            repeat (3) tick();
            check_val($sformatf("%s_hold", tag), bus.out_res, exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ROW_W-1:0] w_spec [4];
      logic [ROW_W-1:0] a_spec [5];
      logic [ROW_W-1:0] w_ff   [4];
      logic [ROW_W-1:0] a_ff   [5];
      logic [ROW_W-1:0] w_rnd  [4];
      logic [ROW_W-1:0] a_rnd  [5];

      w_spec = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
      a_spec = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'hFFFFFFFF};
      w_ff   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      a_ff   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
      for (int i = 0; i < 4; i++) w_rnd[i] = $urandom;
      for (int i = 0; i < 5; i++) a_rnd[i] = $urandom;

      idle_all();
      rst = 1'b1;
      repeat (3) tick();
      check_val("reset_out", bus.out_res, '0);
      rst = 1'b0;
      tick();

      feed(w_spec, a_spec, 4);
      drain(5, "matmul", 1'b1);

      feed(w_spec, a_spec, 5);
      drain(5, "overflow", 1'b0);

      feed(w_ff, a_ff, 4);
      drain(5, "width", 1'b0);

      feed(w_rnd, a_rnd, 4);
      drain(5, "random", 1'b0);

      bus.output_buffer_load_en = 1'b1;
      bus.input_buffer_out_en   = 1'b1;
      repeat (3) tick();
      bus.input_buffer_out_en = 1'b0;
      repeat (LAT + 2) tick();
      bus.output_buffer_load_en = 1'b0;
      drain(1, "empty_pop", 1'b0);

      feed(w_spec, a_spec, 4);
      drain(1, "pre_rst", 1'b0);
      bus.input_buffer_load_en = 1'b1;
      bus.in_act               = a_spec[1];
      tick();
      bus.input_buffer_load_en  = 1'b0;
      bus.input_buffer_out_en   = 1'b1;
      bus.output_buffer_load_en = 1'b1;
      tick();
      bus.input_buffer_out_en = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check_val("rst_mid_out", bus.out_res, '0);
      sb.delete();
      in_cnt = 0;
      idle_all();
      rst = 1'b0;
      repeat (LAT + 2) tick();
      drain(2, "post_rst", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
